// File: rtl/ext_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ext_bus_arbiter
//
// Shares one narrow external memory bus between two requesters: port 0
// (instruction fetch) and port 1 (data). Each 32-bit transaction goes out as
// four 8-bit beats. An address beat carries one address byte, LSB first. A
// write beat carries the matching write-data byte at the same time. A read
// waits TURN_CYCLES idle cycles for bus turnaround, then collects four
// read-data bytes. A one-cycle DONE state then pulses the winner's ack.
// Arbitration is round-robin, and port 0 wins the first contested grant
// after reset.
//
// Parameters
//   TURN_CYCLES  idle cycles between address and read-data phases (0..3)
//
// Ports
//   clk, rst_n             clock; asynchronous active-low reset
//   mN_req/we/addr/wdata   requester N transaction request and payload
//   mN_rdata               requester N read data, held until its next read
//   mN_ack                 requester N one-cycle completion pulse
//   pin_addr, pin_dout     address / write-data byte of the current beat
//   pin_din                read-data byte from external memory
//   pin_oe                 8'hFF while pin_dout is driven, else 8'h00
//   pin_strobe, pin_we     beat valid; beat is a write beat
// ---------------------------------------------------------------------------
module ext_bus_arbiter #(
  parameter int TURN_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic [7:0]  pin_addr,
  output logic [7:0]  pin_dout,
  input  logic [7:0]  pin_din,
  output logic [7:0]  pin_oe,
  output logic        pin_strobe,
  output logic        pin_we
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    TURN,
    READ,
    DONE
  } state_e;

  // Last beat-counter value of the turnaround phase. This value is unused
  // when TURN_CYCLES is 0, because the TURN state is then skipped.
  localparam int         TURN_LAST_I = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;
  localparam logic [1:0] TURN_LAST   = 2'(TURN_LAST_I);

  state_e      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic        last_q, last_d;     // port served most recently
  logic        gnt_q, gnt_d;       // port owning the current transaction
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

  logic        win;
  logic [4:0]  bsel;

  // A sole requester always wins. When both request, the port that was
  // not served last wins.
  assign win  = (m0_req & m1_req) ? ~last_q : m1_req;
  assign bsel = {beat_q, 3'b000};

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;

    case (state_q)
      IDLE: begin
        if (m0_req | m1_req) begin
          gnt_d   = win;
          last_d  = win;
          we_d    = win ? m1_we    : m0_we;
          addr_d  = win ? m1_addr  : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
          beat_d  = 2'd0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        // The beat counter wraps from 3 to 0, which is the starting beat
        // of the next phase.
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          if (we_q) begin
            state_d = DONE;
          end else if (TURN_CYCLES == 0) begin
            state_d = READ;
          end else begin
            state_d = TURN;
          end
        end
      end
      TURN: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == TURN_LAST) begin
          beat_d  = 2'd0;
          state_d = READ;
        end
      end
      READ: begin
        // Each byte lands directly in the owner's rdata at the edge that
        // ends its beat.
        if (gnt_q) begin
          m1_rdata_d[bsel +: 8] = pin_din;
        end else begin
          m0_rdata_d[bsel +: 8] = pin_din;
        end
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= 2'd0;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      m0_rdata_q <= 32'd0;
      m1_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // The latched payload is only observed while ADDR is active, so it
  // needs no reset.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Every pin is decoded from state. A reset therefore forces all pins to
  // zero as soon as it forces IDLE.
  always_comb begin
    pin_addr   = 8'h00;
    pin_dout   = 8'h00;
    pin_oe     = 8'h00;
    pin_strobe = 1'b0;
    pin_we     = 1'b0;
    case (state_q)
      ADDR: begin
        pin_strobe = 1'b1;
        pin_addr   = addr_q[bsel +: 8];
        if (we_q) begin
          pin_we   = 1'b1;
          pin_dout = wdata_q[bsel +: 8];
          pin_oe   = 8'hFF;
        end
      end
      READ: begin
        pin_strobe = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign m0_ack   = (state_q == DONE) & ~gnt_q;
  assign m1_ack   = (state_q == DONE) &  gnt_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ext_bus_arbiter
//
// Self-checking bench for ext_bus_arbiter.
//
// The reference model tracks each transaction as (owner, payload, cycle
// offset since the grant edge). It derives every expected pin, ack and
// rdata value arithmetically from that offset. A compare process checks
// the outputs on every falling edge.
//
// Directed sections pin the model with literal values. They cover reset,
// the write and read examples, round-robin order, an abort during READ,
// and a request dropped mid-transaction. A randomized run follows.
// ---------------------------------------------------------------------------
module tb_ext_bus_arbiter;

  localparam int T = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [31:0] m0_rdata;
  logic        m0_ack;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [31:0] m1_rdata;
  logic        m1_ack;
  logic [7:0]  pin_addr, pin_dout, pin_oe;
  logic [7:0]  pin_din = 8'h00;
  logic        pin_strobe, pin_we;

  always #5 clk = ~clk;

  ext_bus_arbiter #(.TURN_CYCLES(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_rdata  (m0_rdata),
    .m0_ack    (m0_ack),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_rdata  (m1_rdata),
    .m1_ack    (m1_ack),
    .pin_addr  (pin_addr),
    .pin_dout  (pin_dout),
    .pin_din   (pin_din),
    .pin_oe    (pin_oe),
    .pin_strobe(pin_strobe),
    .pin_we    (pin_we)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_busy;
  int          m_k;
  bit          m_port, m_we, m_last;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rd [2];

  function automatic int txn_len(input bit we);
    return we ? 5 : 9 + T;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_k     = 0;
      m_port  = 1'b0;
      m_we    = 1'b0;
      m_last  = 1'b1;
      m_addr  = '0;
      m_wdata = '0;
      m_rd[0] = '0;
      m_rd[1] = '0;
    end else if (!m_busy) begin
      if (m0_req || m1_req) begin
        m_port  = (m0_req && m1_req) ? !m_last : m1_req;
        m_last  = m_port;
        m_we    = m_port ? m1_we    : m0_we;
        m_addr  = m_port ? m1_addr  : m0_addr;
        m_wdata = m_port ? m1_wdata : m0_wdata;
        m_busy  = 1'b1;
        m_k     = 1;
      end
    end else begin
      if (!m_we && m_k >= 5 + T && m_k <= 8 + T)
        m_rd[m_port][8*(m_k-5-T) +: 8] = pin_din;
      if (m_k == txn_len(m_we)) m_busy = 1'b0;
      else m_k++;
    end
  end

  // ---------------- compare process ----------------
  bit         chk_en = 1'b0;
  logic [7:0] e_addr, e_dout, e_oe;
  logic       e_stb, e_we, e_ack0, e_ack1;

  always @(negedge clk) begin
    if (chk_en) begin
      e_addr = 8'h00; e_dout = 8'h00; e_oe = 8'h00;
      e_stb = 1'b0; e_we = 1'b0; e_ack0 = 1'b0; e_ack1 = 1'b0;
      if (m_busy) begin
        if (m_k <= 4) begin
          e_stb  = 1'b1;
          e_addr = m_addr[8*(m_k-1) +: 8];
          if (m_we) begin
            e_we   = 1'b1;
            e_dout = m_wdata[8*(m_k-1) +: 8];
            e_oe   = 8'hFF;
          end
        end else if (!m_we && m_k >= 5 + T && m_k <= 8 + T) begin
          e_stb = 1'b1;
        end
        if (m_k == txn_len(m_we)) begin
          e_ack0 = !m_port;
          e_ack1 = m_port;
        end
      end
      chk("pin_addr", pin_addr, e_addr);
      chk("pin_dout", pin_dout, e_dout);
      chk("pin_oe", pin_oe, e_oe);
      chk("pin_strobe", pin_strobe, e_stb);
      chk("pin_we", pin_we, e_we);
      chk("m0_ack", m0_ack, e_ack0);
      chk("m1_ack", m1_ack, e_ack1);
      chk("m0_rdata", m0_rdata, m_rd[0]);
      chk("m1_rdata", m1_rdata, m_rd[1]);
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] wa [4];
  logic [7:0] wd [4];
  int         nack, acks0, acks1;
  bit         prev_ack;
  bit         order [3];

  task automatic all_zero(input string tag);
    chk({tag, "_addr"}, pin_addr, 8'h00);
    chk({tag, "_dout"}, pin_dout, 8'h00);
    chk({tag, "_oe"}, pin_oe, 8'h00);
    chk({tag, "_strobe"}, pin_strobe, 1'b0);
    chk({tag, "_we"}, pin_we, 1'b0);
    chk({tag, "_ack0"}, m0_ack, 1'b0);
    chk({tag, "_ack1"}, m1_ack, 1'b0);
    chk({tag, "_rd0"}, m0_rdata, 32'h0);
    chk({tag, "_rd1"}, m1_rdata, 32'h0);
  endtask

  // Raise one request, let exactly one grant edge pass, then drop it.
  // The task returns 2 time units into cycle 1 of the transaction.
  task automatic start(input bit port, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    @(posedge clk); #2;
    if (port) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
    @(posedge clk); #2;
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wa = '{8'h78, 8'h56, 8'h34, 8'h12};
    wd = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset release with no request: the DUT stays idle.
    repeat (3) @(negedge clk);
    all_zero("idle_after_rst");
    // Asynchronous reset mid-idle.
    #2 rst_n = 1'b0;
    #1 all_zero("async_rst_idle");
    @(posedge clk); #2 rst_n = 1'b1;

    // Write from port 0.
    start(1'b0, 1'b1, 32'h12345678, 32'hA1B2C3D4);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        chk("wr_pin_addr", pin_addr, wa[k-1]);
        chk("wr_pin_dout", pin_dout, wd[k-1]);
        chk("wr_pin_oe", pin_oe, 8'hFF);
      end
      chk("wr_m0_ack", m0_ack, (k == 5));
    end
    repeat (2) @(posedge clk);

    // Read from port 1 with data bytes 11, 22, 33, 44.
    start(1'b1, 1'b0, 32'h00000010, 32'h0);
    for (int k = 1; k <= 9 + T; k++) begin
      @(negedge clk);
      if (k >= 5 + T && k <= 8 + T) pin_din = 8'(8'h11 * (k - 4 - T));
      else pin_din = 8'h00;
      chk("rd_m1_ack", m1_ack, (k == 9 + T));
    end
    chk("rd_m1_rdata", m1_rdata, 32'h44332211);
    chk("rd_m0_rdata_kept", m0_rdata, 32'h0);
    repeat (2) @(posedge clk);

    // Port 0 read; its request drops during ADDR beat 1.
    @(posedge clk); #2;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'hCAFE0004;
    pin_din = 8'h3C;
    @(posedge clk); #2;
    @(posedge clk); #2;
    m0_req = 1'b0;
    acks0 = 0; acks1 = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      acks0 += int'(m0_ack);
      acks1 += int'(m1_ack);
    end
    chk("drop_m0_ack_count", acks0, 1);
    chk("drop_m1_ack_count", acks1, 0);
    chk("drop_m0_rdata", m0_rdata, 32'h3C3C3C3C);

    // Reset during READ beat 2 of a port 1 read.
    start(1'b1, 1'b0, 32'h00000020, 32'h0);
    pin_din = 8'h77;
    for (int k = 1; k <= 7 + T; k++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 all_zero("rst_in_read");
    @(posedge clk); #2 rst_n = 1'b1;
    acks0 = 0; acks1 = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      acks0 += int'(m0_ack);
      acks1 += int'(m1_ack);
    end
    chk("abort_ack0", acks0, 0);
    chk("abort_ack1", acks1, 0);
    chk("abort_m1_rdata", m1_rdata, 32'h0);

    // Both ports request continuously from reset.
    @(negedge clk); #2 rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h00000100; m0_wdata = 32'h55AA55AA;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h00000200;
    pin_din = 8'h5A;
    @(posedge clk); #2 rst_n = 1'b1;
    nack = 0; prev_ack = 1'b0;
    for (int c = 0; c < 80 && nack < 3; c++) begin
      @(negedge clk);
      if (prev_ack) chk("rr_idle_gap_strobe", pin_strobe, 1'b0);
      prev_ack = m0_ack | m1_ack;
      if (prev_ack) begin
        order[nack] = m1_ack;
        nack++;
      end
    end
    #1 m0_req = 1'b0; m1_req = 1'b0;
    chk("rr_ack_count", nack, 3);
    chk("rr_order_0", order[0], 1'b0);
    chk("rr_order_1", order[1], 1'b1);
    chk("rr_order_2", order[2], 1'b0);
    repeat (3) @(posedge clk);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #2;
      m0_req   = ($urandom_range(0, 1) == 1);
      m1_req   = ($urandom_range(0, 1) == 1);
      m0_we    = ($urandom_range(0, 1) == 1);
      m1_we    = ($urandom_range(0, 1) == 1);
      m0_addr  = $urandom();
      m1_addr  = $urandom();
      m0_wdata = $urandom();
      m1_wdata = $urandom();
      pin_din  = 8'($urandom());
    end
    @(posedge clk); #2;
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
